pzbcm_stream_arbiter: RTL

Round-robin arbiter that shares one valid/ready output stream among REQUESTERS input streams, with optional packet locking so a multi-beat packet is never interleaved. It sequences the one-hot data multiplexer in the selector library: it chooses the winner, drives the mux select, and registers the selected beat into a single output stage. It sits in front of any shared sink such as a bus port, FIFO write side or common pipeline.

---
 rtl/pzbcm_stream_arbiter_pkg.sv | 9 +
 rtl/pzbcm_mux.sv | 40 ++++
 rtl/pzbcm_stream_arbiter.sv | 117 +++++++++++
 3 files changed

// File: rtl/pzbcm_stream_arbiter_pkg.sv
// Shared types for the round-robin stream arbiter.
package pzbcm_stream_arbiter_pkg;

  typedef enum logic {
    IDLE,
    LOCKED
  } pzbcm_stream_arbiter_state_e;

endpackage

// File: rtl/pzbcm_mux.sv
// Data multiplexer: one-hot select (ONE_HOT=1) or binary index select (ONE_HOT=0).
module pzbcm_mux #(
  parameter int  ENTRIES      = 2,
  parameter bit  ONE_HOT      = 1,
  parameter type TYPE         = logic [7:0],
  parameter int  SELECT_WIDTH = ONE_HOT ? ENTRIES : ((ENTRIES > 1) ? $clog2(ENTRIES) : 1)
)(
  input  logic [SELECT_WIDTH-1:0] i_select,
  input  TYPE                     i_data[ENTRIES],
  output TYPE                     o_data
);
  localparam int DW = $bits(TYPE);

  logic [DW-1:0] data_bits;

  generate
    if (ONE_HOT) begin : g_one_hot
      always_comb begin
        data_bits = '0;
        for (int i = 0; i < ENTRIES; i++) begin
          if (i_select[i]) begin
            data_bits = data_bits | DW'(i_data[i]);
          end
        end
      end
    end else begin : g_binary
      always_comb begin
        data_bits = '0;
        for (int i = 0; i < ENTRIES; i++) begin
          if (int'(i_select) == i) begin
            data_bits = DW'(i_data[i]);
          end
        end
      end
    end
  endgenerate

  assign o_data = TYPE'(data_bits);

endmodule

// File: rtl/pzbcm_stream_arbiter.sv
// Round-robin arbiter merging REQUESTERS valid/ready streams into one registered
// output stage, optionally holding the grant for a whole packet.
module pzbcm_stream_arbiter
  import pzbcm_stream_arbiter_pkg::*;
#(
  parameter int  WIDTH      = 8,
  parameter type TYPE       = logic [WIDTH-1:0],
  parameter int  REQUESTERS = 2,
  parameter bit  KEEP_GRANT = 1
)(
  input  logic                  i_clk,
  input  logic                  i_rst_n,
  input  logic [REQUESTERS-1:0] i_valid,
  output logic [REQUESTERS-1:0] o_ready,
  input  TYPE                   i_data[REQUESTERS],
  input  logic [REQUESTERS-1:0] i_last,
  output logic                  o_valid,
  input  logic                  i_ready,
  output TYPE                   o_data,
  output logic                  o_last,
  output logic [REQUESTERS-1:0] o_grant
);
  localparam int PW = (REQUESTERS > 1) ? $clog2(REQUESTERS) : 1;

  // Rotate so ptr sits at bit 0, take the lowest set bit, rotate back.
  function automatic logic [REQUESTERS-1:0] rr_find(
    input logic [REQUESTERS-1:0] req,
    input logic [PW-1:0]         start
  );
    logic [2*REQUESTERS-1:0] dbl;
    logic [REQUESTERS-1:0]   rot;
    logic [REQUESTERS-1:0]   hit;
    logic                    found;
    dbl   = {req, req} >> start;
    rot   = dbl[REQUESTERS-1:0];
    hit   = '0;
    found = 1'b0;
    for (int i = 0; i < REQUESTERS; i++) begin
      if (rot[i] && !found) begin
        hit[i] = 1'b1;
        found  = 1'b1;
      end
    end
    dbl = {hit, hit} << start;
    return dbl[2*REQUESTERS-1:REQUESTERS];
  endfunction

  pzbcm_stream_arbiter_state_e state;
  logic [REQUESTERS-1:0]       grant_q;
  logic [PW-1:0]               ptr;
  logic [REQUESTERS-1:0]       grant;
  logic [PW-1:0]               grant_idx;
  logic [PW-1:0]               next_ptr;
  logic                        load;
  logic                        transfer;
  logic                        sel_last;
  TYPE                         sel_data;

  assign grant    = (state == LOCKED) ? grant_q : rr_find(i_valid, ptr);
  assign load     = !o_valid || i_ready;
  assign o_ready  = grant & {REQUESTERS{load}};
  assign o_grant  = grant;
  assign transfer = |(i_valid & o_ready);
  assign sel_last = |(i_last & grant);

  always_comb begin
    grant_idx = '0;
    for (int i = 0; i < REQUESTERS; i++) begin
      if (grant[i]) begin
        grant_idx = PW'(i);
      end
    end
  end

  // Explicit wrap so non-power-of-two counts never land on an unused index.
  assign next_ptr = (grant_idx == PW'(REQUESTERS - 1)) ? '0 : grant_idx + PW'(1);

  pzbcm_mux #(
    .ENTRIES (REQUESTERS),
    .ONE_HOT (1),
    .TYPE    (TYPE)
  ) u_data_mux (
    .i_select (grant),
    .i_data   (i_data),
    .o_data   (sel_data)
  );

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state   <= IDLE;
      grant_q <= '0;
      ptr     <= '0;
      o_valid <= 1'b0;
      o_data  <= TYPE'('0);
      o_last  <= 1'b0;
    end else begin
      if (load) begin
        o_valid <= transfer;
      end
      if (transfer) begin
        o_data <= sel_data;
        o_last <= sel_last;
        if (state == IDLE && !sel_last && KEEP_GRANT) begin
          state   <= LOCKED;
          grant_q <= grant;
        end else if (state == LOCKED && sel_last) begin
          state   <= IDLE;
          grant_q <= '0;
        end
        if (sel_last || !KEEP_GRANT) begin
          ptr <= next_ptr;
        end
      end
    end
  end

endmodule
